pilot_tone_sequencer: RTL and testbench

//  Sequences the pilot-tone divider through a programmable table of {hiDivide, loDivide, dwell}.

---
 rtl/pilot_tone_pkg.sv | 27 ++
 rtl/pilot_tone_table.sv | 40 ++++
 rtl/pilot_tone_sequencer.sv | 154 +++++++++++++++
 tb/tb_pilot_tone_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pilot_tone_pkg.sv
// Shared definitions for the pilot-tone sequencer: FSM states, GPIO word
// field positions and the divider data packing.
package pilot_tone_pkg;

    localparam int unsigned PT_COUNTER_WIDTH = 10;

    localparam int unsigned WORD_TYPE_BIT   = 31;
    localparam int unsigned TABLE_INDEX_LSB = 27;
    localparam int unsigned HI_LSB          = 10;
    localparam int unsigned LO_LSB          = 0;
    localparam int unsigned CSR_RUN_BIT     = 0;
    localparam int unsigned CSR_ONESHOT_BIT = 1;
    localparam int unsigned CSR_LAST_LSB    = 8;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        DWELL
    } ptState_t;

    function automatic logic [31:0] packPtData(input logic [PT_COUNTER_WIDTH-1:0] hi,
                                               input logic [PT_COUNTER_WIDTH-1:0] lo);
        return {{(32 - 2 * PT_COUNTER_WIDTH){1'b0}}, hi, lo};
    endfunction

endpackage

// File: rtl/pilot_tone_table.sv
// Sequence table RAM: divider and dwell fields are written independently,
// one synchronous read port.
module pilot_tone_table
    import pilot_tone_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned DWELL_WIDTH   = 16,
    parameter int unsigned COUNTER_WIDTH = PT_COUNTER_WIDTH
) (
    input  logic                     sysClk,
    input  logic                     divWrite,
    input  logic                     dwellWrite,
    input  logic [ADDR_WIDTH-1:0]    writeIndex,
    input  logic [COUNTER_WIDTH-1:0] writeHi,
    input  logic [COUNTER_WIDTH-1:0] writeLo,
    input  logic [DWELL_WIDTH-1:0]   writeDwell,
    input  logic [ADDR_WIDTH-1:0]    readIndex,
    output logic [COUNTER_WIDTH-1:0] readHi,
    output logic [COUNTER_WIDTH-1:0] readLo,
    output logic [DWELL_WIDTH-1:0]   readDwell
);

    localparam int unsigned ENTRY_WIDTH = 2 * COUNTER_WIDTH + DWELL_WIDTH;

    logic [ENTRY_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ENTRY_WIDTH-1:0] readWord;

    always_ff @(posedge sysClk) begin
        if (divWrite) begin
            mem[writeIndex][ENTRY_WIDTH-1 -: 2*COUNTER_WIDTH] <= {writeHi, writeLo};
        end
        if (dwellWrite) begin
            mem[writeIndex][DWELL_WIDTH-1:0] <= writeDwell;
        end
        readWord <= mem[readIndex];
    end

    assign {readHi, readLo, readDwell} = readWord;

endmodule

// File: rtl/pilot_tone_sequencer.sv
// Steps the pilot-tone divider through the table, dwelling on each entry for a
// programmed number of ticks; also forwards CPU manual divider writes when idle.
module pilot_tone_sequencer
    import pilot_tone_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 3,
    parameter int unsigned DWELL_WIDTH   = 16,
    parameter int unsigned COUNTER_WIDTH = PT_COUNTER_WIDTH
) (
    input  logic        sysClk,
    input  logic        sysReset,
    input  logic        csrStrobe,
    input  logic        tableStrobe,
    input  logic [31:0] GPIO_OUT,
    input  logic        tick,
    output logic [31:0] csr,
    output logic        ptStrobe,
    output logic [31:0] ptData,
    output logic        active
);

    localparam logic [3:0] MAX_INDEX = 4'((1 << ADDR_WIDTH) - 1);

    ptState_t                 state;
    logic [ADDR_WIDTH-1:0]    index;
    logic [3:0]               lastIndex;
    logic                     run;
    logic                     oneShot;
    logic                     done;
    logic                     reject;
    logic [DWELL_WIDTH-1:0]   dwellCount;
    logic [31:0]              ptDataReg;
    logic [31:0]              issueData;
    logic [COUNTER_WIDTH-1:0] readHi;
    logic [COUNTER_WIDTH-1:0] readLo;
    logic [DWELL_WIDTH-1:0]   readDwell;
    logic                     ctrlWrite;
    logic                     manualWrite;
    logic                     unusedGpio;

    function automatic logic [3:0] clampLast(input logic [3:0] req);
        return (req > MAX_INDEX) ? MAX_INDEX : req;
    endfunction

    assign ctrlWrite   = csrStrobe & ~GPIO_OUT[WORD_TYPE_BIT];
    assign manualWrite = csrStrobe &  GPIO_OUT[WORD_TYPE_BIT];
    assign unusedGpio  = ^GPIO_OUT;

    pilot_tone_table #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DWELL_WIDTH  (DWELL_WIDTH),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) table0 (
        .sysClk    (sysClk),
        .divWrite  (tableStrobe & ~GPIO_OUT[WORD_TYPE_BIT]),
        .dwellWrite(tableStrobe &  GPIO_OUT[WORD_TYPE_BIT]),
        .writeIndex(GPIO_OUT[TABLE_INDEX_LSB +: ADDR_WIDTH]),
        .writeHi   (GPIO_OUT[HI_LSB +: COUNTER_WIDTH]),
        .writeLo   (GPIO_OUT[LO_LSB +: COUNTER_WIDTH]),
        .writeDwell(GPIO_OUT[DWELL_WIDTH-1:0]),
        .readIndex (index),
        .readHi    (readHi),
        .readLo    (readLo),
        .readDwell (readDwell)
    );

    assign issueData = packPtData(readHi, readLo);

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state      <= IDLE;
            index      <= '0;
            lastIndex  <= '0;
            run        <= 1'b0;
            oneShot    <= 1'b0;
            done       <= 1'b0;
            reject     <= 1'b0;
            dwellCount <= '0;
            ptStrobe   <= 1'b0;
            ptDataReg  <= '0;
        end else begin
            ptStrobe <= 1'b0;
            // Table read data is only valid in ISSUE, so hold what the divider just latched.
            if (state == ISSUE) begin
                ptDataReg <= issueData;
            end
            if (ctrlWrite) begin
                run       <= GPIO_OUT[CSR_RUN_BIT];
                oneShot   <= GPIO_OUT[CSR_ONESHOT_BIT];
                lastIndex <= clampLast(GPIO_OUT[CSR_LAST_LSB +: 4]);
                done      <= 1'b0;
                reject    <= 1'b0;
                if (GPIO_OUT[CSR_RUN_BIT]) begin
                    index      <= '0;
                    dwellCount <= '0;
                    state      <= FETCH;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (manualWrite) begin
                            ptStrobe  <= 1'b1;
                            ptDataReg <= packPtData(GPIO_OUT[HI_LSB +: COUNTER_WIDTH],
                                                    GPIO_OUT[LO_LSB +: COUNTER_WIDTH]);
                        end
                    end
                    FETCH: begin
                        if (run) begin
                            state    <= ISSUE;
                            ptStrobe <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    ISSUE: begin
                        dwellCount <= readDwell;
                        state      <= DWELL;
                    end
                    DWELL: begin
                        if (tick && dwellCount != '0) begin
                            dwellCount <= dwellCount - 1'b1;
                            if (dwellCount == DWELL_WIDTH'(1)) begin
                                if (index == lastIndex[ADDR_WIDTH-1:0]) begin
                                    index <= '0;
                                    if (oneShot) begin
                                        state <= IDLE;
                                        run   <= 1'b0;
                                        done  <= 1'b1;
                                    end else begin
                                        state <= FETCH;
                                    end
                                end else begin
                                    index <= index + 1'b1;
                                    state <= FETCH;
                                end
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
                if (manualWrite && state != IDLE) begin
                    reject <= 1'b1;
                end
            end
        end
    end

    assign ptData = (state == ISSUE) ? issueData : ptDataReg;
    assign active = (state != IDLE);
    assign csr    = {active, done, reject, 1'b0, 4'(index), lastIndex, 4'b0, 16'(dwellCount)};

endmodule

// File: tb/tb_pilot_tone_sequencer.sv
// Scoreboard bench for pilot_tone_sequencer: a small sequencer model queues
// expected divider strobes (data and cycle), a negedge monitor retires them.
module tb_pilot_tone_sequencer;

    logic        sysClk = 1'b0;
    logic        sysReset;
    logic        csrStrobe;
    logic        tableStrobe;
    logic [31:0] GPIO_OUT;
    logic        tick;
    logic [31:0] csr;
    logic        ptStrobe;
    logic [31:0] ptData;
    logic        active;

    pilot_tone_sequencer #(
        .ADDR_WIDTH   (3),
        .DWELL_WIDTH  (16),
        .COUNTER_WIDTH(10)
    ) dut (
        .sysClk     (sysClk),
        .sysReset   (sysReset),
        .csrStrobe  (csrStrobe),
        .tableStrobe(tableStrobe),
        .GPIO_OUT   (GPIO_OUT),
        .tick       (tick),
        .csr        (csr),
        .ptStrobe   (ptStrobe),
        .ptData     (ptData),
        .active     (active)
    );

    always #5 sysClk = ~sysClk;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } expStrobe_t;

    expStrobe_t sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       prevStrobe = 1'b0;

    logic [9:0]  mHi [8];
    logic [9:0]  mLo [8];
    logic [15:0] mDwell [8];
    bit          mRun = 0;
    bit          mOneShot = 0;
    int          mIdx = 0;
    int          mLast = 0;
    int          mRemain = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic pushEntry(input int i, input int when);
        expStrobe_t e;
        e.data = {12'b0, mHi[i], mLo[i]};
        e.cyc  = when;
        sb.push_back(e);
    endtask

    task automatic modelTick(input int t);
        if (mRun && mRemain > 0) begin
            mRemain--;
            if (mRemain == 0) begin
                if (mIdx == mLast && mOneShot) begin
                    mRun = 0;
                end else begin
                    mIdx = (mIdx == mLast) ? 0 : mIdx + 1;
                    pushEntry(mIdx, t + 2);
                    mRemain = int'(mDwell[mIdx]);
                end
            end
        end
    endtask

    task automatic modelCsr(input logic [31:0] w, input int c);
        expStrobe_t e;
        if (w[31]) begin
            if (!mRun) begin
                e.data = {12'b0, w[19:0]};
                e.cyc  = c + 1;
                sb.push_back(e);
            end
        end else begin
            mOneShot = w[1];
            mLast    = (w[11:8] > 4'd7) ? 7 : int'(w[11:8]);
            mRun     = w[0];
            if (w[0]) begin
                mIdx    = 0;
                mRemain = int'(mDwell[0]);
                pushEntry(0, c + 2);
            end
        end
    endtask

    function automatic logic [31:0] ctrlWord(input bit runBit, input bit oneShotBit, input int last);
        return {20'b0, 4'(last), 6'b0, oneShotBit, runBit};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge sysClk);
        #1;
    endtask

    task automatic csrWrite(input logic [31:0] w);
        @(posedge sysClk);
        #1;
        csrStrobe = 1'b1;
        GPIO_OUT  = w;
        modelCsr(w, cyc);
        @(posedge sysClk);
        #1;
        csrStrobe = 1'b0;
        GPIO_OUT  = '0;
    endtask

    task automatic tableWrite(input int i, input int hi, input int lo, input int dw);
        @(posedge sysClk);
        #1;
        tableStrobe = 1'b1;
        GPIO_OUT    = {1'b0, 4'(i), 7'b0, 10'(hi), 10'(lo)};
        mHi[i]      = 10'(hi);
        mLo[i]      = 10'(lo);
        @(posedge sysClk);
        #1;
        GPIO_OUT    = {1'b1, 4'(i), 11'b0, 16'(dw)};
        mDwell[i]   = 16'(dw);
        @(posedge sysClk);
        #1;
        tableStrobe = 1'b0;
        GPIO_OUT    = '0;
    endtask

    task automatic tickN(input int n);
        repeat (n) begin
            repeat (3) @(posedge sysClk);
            #1;
            tick = 1'b1;
            modelTick(cyc);
            @(posedge sysClk);
            #1;
            tick = 1'b0;
        end
    endtask

    // Control write and the final dwell tick land in the same cycle.
    task automatic csrTick(input logic [31:0] w);
        repeat (3) @(posedge sysClk);
        #1;
        csrStrobe = 1'b1;
        tick      = 1'b1;
        GPIO_OUT  = w;
        modelCsr(w, cyc);
        @(posedge sysClk);
        #1;
        csrStrobe = 1'b0;
        tick      = 1'b0;
        GPIO_OUT  = '0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkEq({tag, "PtStrobe"}, 32'(ptStrobe), 32'd0);
        checkEq({tag, "PtData"}, ptData, 32'd0);
        checkEq({tag, "Active"}, 32'(active), 32'd0);
        checkEq({tag, "Csr"}, csr, 32'd0);
    endtask

    always @(posedge sysClk) cyc <= cyc + 1;

    always @(negedge sysClk) begin : monitor
        expStrobe_t e;
        if (!sysReset && ptStrobe) begin
            checkEq("strobeExpected", 32'(sb.size() > 0), 32'd1);
            checkEq("noBackToBack", 32'(prevStrobe), 32'd0);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkEq("ptData", ptData, e.data);
                checkEq("strobeCycle", 32'(cyc), 32'(e.cyc));
            end
        end
        prevStrobe = ptStrobe;
    end

    initial begin
        sysReset    = 1'b1;
        csrStrobe   = 1'b0;
        tableStrobe = 1'b0;
        tick        = 1'b0;
        GPIO_OUT    = '0;
        idle(3);
        checkResetOutputs("reset");
        sysReset = 1'b0;

        tableWrite(0, 5, 5, 2);
        tableWrite(1, 10, 20, 1);
        tableWrite(2, 1, 1, 3);

        // Continuous run with wrap to entry 0.
        csrWrite(ctrlWord(1, 0, 2));
        tickN(2);
        checkEq("csrIndex", 32'(csr[27:24]), 32'd1);
        checkEq("csrLast", 32'(csr[23:20]), 32'd2);
        tickN(1);
        tickN(3);
        tickN(2);
        checkEq("runActive", 32'(active), 32'd1);
        csrWrite(ctrlWord(0, 0, 2));
        idle(5);
        checkEq("pendingRun", 32'(sb.size()), 32'd0);

        // One-shot pass.
        csrWrite(ctrlWord(1, 1, 2));
        tickN(2);
        tickN(1);
        tickN(3);
        idle(2);
        checkEq("oneShotActive", 32'(active), 32'd0);
        checkEq("oneShotDone", 32'(csr[30]), 32'd1);
        checkEq("pendingOneShot", 32'(sb.size()), 32'd0);

        // Manual writes: accepted when idle, rejected while running.
        csrWrite(32'h8000_0C03);
        idle(3);
        csrWrite(ctrlWord(1, 0, 2));
        checkEq("doneCleared", 32'(csr[30]), 32'd0);
        idle(3);
        csrWrite(32'h8000_0C03);
        idle(3);
        checkEq("rejectSet", 32'(csr[29]), 32'd1);
        csrWrite(ctrlWord(0, 0, 2));
        checkEq("rejectCleared", 32'(csr[29]), 32'd0);
        checkEq("pendingManual", 32'(sb.size()), 32'd0);

        csrWrite(ctrlWord(0, 0, 15));
        checkEq("lastClamp", 32'(csr[23:20]), 32'd7);

        // Zero dwell holds indefinitely.
        tableWrite(0, 5, 5, 0);
        csrWrite(ctrlWord(1, 0, 2));
        tickN(100);
        checkEq("dwellZeroActive", 32'(active), 32'd1);
        checkEq("dwellZeroIndex", 32'(csr[27:24]), 32'd0);
        checkEq("dwellZeroCount", 32'(csr[15:0]), 32'd0);
        csrWrite(ctrlWord(0, 0, 2));
        checkEq("stopActive", 32'(active), 32'd0);
        idle(5);
        checkEq("pendingDwellZero", 32'(sb.size()), 32'd0);
        tableWrite(0, 5, 5, 2);

        // Stop coincident with the final dwell tick.
        csrWrite(ctrlWord(1, 0, 2));
        tickN(1);
        checkEq("dwellCountMid", 32'(csr[15:0]), 32'd1);
        csrTick(ctrlWord(0, 0, 2));
        checkEq("stopTickActive", 32'(active), 32'd0);
        idle(5);
        checkEq("pendingStopTick", 32'(sb.size()), 32'd0);

        // Reset mid-dwell; table survives.
        csrWrite(ctrlWord(1, 0, 2));
        tickN(1);
        idle(1);
        @(posedge sysClk);
        #1;
        sysReset = 1'b1;
        @(posedge sysClk);
        #1;
        checkResetOutputs("midReset");
        sysReset = 1'b0;
        mRun     = 0;
        mOneShot = 0;
        mLast    = 0;
        csrWrite(ctrlWord(1, 0, 2));
        tickN(2);
        csrWrite(ctrlWord(0, 0, 2));
        idle(5);
        checkEq("pendingRerun", 32'(sb.size()), 32'd0);

        // Rewrite the next entry while the current one dwells.
        csrWrite(ctrlWord(1, 0, 2));
        tableWrite(1, 7, 9, 1);
        tickN(2);
        csrWrite(ctrlWord(0, 0, 2));
        idle(5);
        checkEq("pendingRewrite", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
